div_seq32: RTL and testbench

Multi-cycle 32-bit integer divider that sequences one restoring trial-subtraction per clock to implement RV32M DIV, DIVU, REM and REMU. It sits beside the ALU in the execute stage. The core pipeline starts it with a one-cycle pulse, holds the instruction while `busy` is high, and writes back `result` on the `done` pulse. It owns all operand latching, sign handling and RISC-V special-case results, so the pipeline only sees a start/done handshake.

---
 rtl/div_seq32_pkg.sv | 22 ++
 rtl/div_seq32_step.sv | 32 +++
 rtl/div_seq32.sv | 166 ++++++++++++++++
 tb/tb_div_seq32.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/div_seq32_pkg.sv
// Shared definitions for the sequential RV32M divider: op encodings,
// controller states and the fixed results of the RISC-V special cases.
package div_seq32_pkg;

  // funct3[1:0] of the M-extension divide group
  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Quotient for divide-by-zero, and the most negative 32-bit value
  localparam logic [31:0] QUO_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [31:0] SIGNED_MIN   = 32'h8000_0000;

endpackage

// File: rtl/div_seq32_step.sv
// One restoring division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference when it
// does not go negative, and shift the outcome bit into the quotient.
module div_step #(
  parameter int N = 32
) (
  input  logic [N:0]   r_in,
  input  logic [N-1:0] q_in,
  input  logic [N-1:0] divisor,
  output logic [N:0]   r_out,
  output logic [N-1:0] q_out
);

  // The partial remainder's top bit is always zero between iterations;
  // carrying it into the subtraction keeps the sign test exact regardless.
  logic [N+1:0] trial;
  logic [N+1:0] diff;

  // Trial subtraction and restore/accept selection
  always_comb begin
    trial = {r_in, q_in[N-1]};
    diff  = trial - {2'b00, divisor};
    if (!diff[N+1]) begin
      r_out = diff[N:0];
      q_out = {q_in[N-2:0], 1'b1};
    end else begin
      r_out = trial[N:0];
      q_out = {q_in[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_seq32.sv
// Multi-cycle RV32M DIV/DIVU/REM/REMU unit. Operands are reduced to unsigned
// magnitudes at start, one restoring step runs per clock, and the sign is
// reapplied in a single fix-up cycle before the result is presented.
module div_seq32
  import div_seq32_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int           CNT_W    = $clog2(N);
  localparam logic [N-1:0] ALL_ONES = N'(QUO_ALL_ONES);
  localparam logic [N-1:0] SMIN     = N'(SIGNED_MIN);

  state_e             state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [N:0]         r_q,       r_d;
  logic [N-1:0]       q_q,       q_d;
  logic [N-1:0]       dvs_q,     dvs_d;
  logic [N-1:0]       result_q,  result_d;
  logic               rem_q,     rem_d;
  logic               qneg_q,    qneg_d;
  logic               rneg_q,    rneg_d;
  logic               special_q, special_d;

  logic               signed_op;
  logic [N:0]         r_step;
  logic [N-1:0]       q_step;

  function automatic logic [N-1:0] twos_neg(input logic [N-1:0] x);
    return ~x + N'(1);
  endfunction

  // Unsigned magnitude; the most negative value maps onto itself, which is
  // its correct unsigned magnitude.
  function automatic logic [N-1:0] magnitude(input logic signed [N-1:0] x,
                                             input logic                is_signed);
    return (is_signed && (x < 0)) ? twos_neg(x) : x;
  endfunction

  // Preloaded special-case results are already final and skip the negation.
  function automatic logic [N-1:0] apply_sign(input logic [N-1:0] quo,
                                              input logic [N-1:0] rem,
                                              input logic         sel_rem,
                                              input logic         quo_neg,
                                              input logic         rem_neg,
                                              input logic         special);
    logic [N-1:0] val;
    logic         neg;
    val = sel_rem ? rem : quo;
    neg = !special && (sel_rem ? rem_neg : quo_neg);
    return neg ? twos_neg(val) : val;
  endfunction

  assign signed_op = (op != OP_DIVU) && (op != OP_REMU);

  div_step #(.N(N)) u_step (
    .r_in    (r_q),
    .q_in    (q_q),
    .divisor (dvs_q),
    .r_out   (r_step),
    .q_out   (q_step)
  );

  // Next-state, operand capture, iteration and fix-up logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    q_d       = q_q;
    dvs_d     = dvs_q;
    result_d  = result_q;
    rem_d     = rem_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    special_d = special_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          rem_d     = (op == OP_REM) || (op == OP_REMU);
          qneg_d    = signed_op && (dividend[N-1] ^ divisor[N-1]);
          rneg_d    = signed_op && dividend[N-1];
          cnt_d     = '0;
          r_d       = '0;
          q_d       = magnitude(dividend, signed_op);
          dvs_d     = magnitude(divisor, signed_op);
          special_d = 1'b0;
          state_d   = ST_CALC;
          if (divisor == '0) begin
            special_d = 1'b1;
            q_d       = ALL_ONES;
            r_d       = {1'b0, dividend};
            state_d   = ST_FIX;
          end else if (signed_op && (dividend == SMIN) && (divisor == ALL_ONES)) begin
            special_d = 1'b1;
            q_d       = SMIN;
            r_d       = '0;
            state_d   = ST_FIX;
          end
        end
      end
      // iteration stage: one quotient bit per clock
      ST_CALC: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          state_d = ST_FIX;
        end
      end
      // fix-up stage: select and sign-correct
      ST_FIX: begin
        result_d = apply_sign(q_q, r_q[N-1:0], rem_q, qneg_q, rneg_q, special_q);
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      dvs_q     <= '0;
      result_q  <= '0;
      rem_q     <= 1'b0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      special_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      q_q       <= q_d;
      dvs_q     <= dvs_d;
      result_q  <= result_d;
      rem_q     <= rem_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      special_q <= special_d;
    end
  end

  assign busy   = (state_q == ST_CALC) || (state_q == ST_FIX);
  assign done   = (state_q == ST_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_div_seq32.sv
// Randomized scoreboard bench for div_seq32: the driver pushes the expected
// result and latency for each accepted operation, a monitor pops and compares
// on every done pulse.
module tb_div_seq32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  typedef struct {
    logic [31:0] res;
    int          s;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fails  = 0;
  int   cyc      = 0;

  div_seq32 #(.N(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: RISC-V M-extension semantics with plain integer arithmetic
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa = $signed(a);
    int sb2 = $signed(b);
    logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    case (o)
      2'b00:   return ovf ? 32'h8000_0000 : 32'(sa / sb2);
      2'b01:   return a / b;
      2'b10:   return ovf ? 32'd0 : 32'(sa % sb2);
      default: return a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'd0) ||
           (!o[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
  endfunction

  task automatic check_val(input string name, input logic [31:0] act,
                           input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_done: got done=1 result=%h, required no done", result);
      end else begin
        mon_e = sb.pop_front();
        check_val({mon_e.name, "_result"}, result, mon_e.res);
        check_val({mon_e.name, "_latency"}, 32'(cyc - mon_e.s), 32'(mon_e.lat));
        check_val({mon_e.name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
      end
    end
  end

  // Issue one operation and wait (bounded) for its done pulse. With poke set,
  // stray starts are driven mid-calculation and in the done cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string name, input bit poke);
    exp_t e;
    bit   got;
    @(negedge clk);
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.res  = ref_div(o, a, b);
    e.s    = cyc;
    e.lat  = is_special(o, a, b) ? 2 : 34;
    e.name = name;
    sb.push_back(e);
    got = 1'b0;
    for (int i = 1; i <= 60 && !got; i++) begin
      @(negedge clk);
      start = poke && (i == 5);
      if (start) begin
        op       = 2'($urandom);
        dividend = $urandom;
        divisor  = $urandom;
      end
      if (i == 1) check_val({name, "_busy_after_start"}, {31'd0, busy}, 32'd1);
      if (done === 1'b1) begin
        got = 1'b1;
        if (poke) begin
          start    = 1'b1;
          op       = 2'($urandom);
          dividend = $urandom;
          divisor  = $urandom;
        end
      end
    end
    if (!got) begin
      n_checks++;
      n_fails++;
      $display("FAIL %s_timeout: got no done in 60 cycles, required done", name);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got simulation still running, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    int          dones;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    reset    = 1'b1;
    start    = 1'b0;
    op       = 2'b00;
    dividend = 32'd0;
    divisor  = 32'd0;
    repeat (3) @(negedge clk);
    check_val("reset_busy",   {31'd0, busy}, 32'd0);
    check_val("reset_done",   {31'd0, done}, 32'd0);
    check_val("reset_result", result, 32'd0);
    reset = 1'b0;

    // Directed cases; the first follows with a start one cycle after done
    run_op(2'b01, 32'd100, 32'd7, "divu_100_7", 1'b1);
    run_op(2'b11, 32'd100, 32'd7, "remu_100_7", 1'b0);
    run_op(2'b00, 32'hFFFF_FFF9, 32'd2, "div_m7_2", 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "rem_m7_2", 1'b0);
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, "rem_7_m2", 1'b0);
    run_op(2'b01, 32'd5, 32'd0, "divu_by_zero", 1'b0);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, "rem_by_zero", 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow", 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "rem_overflow", 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'd1, "divu_max_1", 1'b0);
    run_op(2'b00, 32'h8000_0000, 32'd1, "div_min_1", 1'b0);

    // Abort a DIVU 10 cycles in; no done may follow
    @(negedge clk);
    op       = 2'b01;
    dividend = 32'd123456;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_val("abort_busy",   {31'd0, busy}, 32'd0);
    check_val("abort_result", result, 32'd0);
    reset = 1'b0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check_val("abort_no_done", 32'(dones), 32'd0);
    run_op(2'b01, 32'd9, 32'd3, "divu_9_3_after_abort", 1'b0);

    // Randomized operations with biased corner operands
    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = $urandom_range(1, 15);
        3: ra = 32'h8000_0000;
        4: ra = $urandom_range(0, 20);
        default: ;
      endcase
      run_op(ro, ra, rb, $sformatf("rand%0d", n), 1'b0);
    end

    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check_val("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
